// File: rtl/rw_preamble_stream.sv
// Preamble generator followed by a valid/ready payload stream with a per-word transform.
// An optional payload frame length re-inserts the preamble every FRAME_LEN words.
module rw_preamble_stream #(
  parameter int unsigned W         = 8,
  parameter int unsigned PRE_LEN   = 4,
  parameter logic [63:0] PRE_SEED  = 64'hA5,
  parameter logic [63:0] PRE_STEP  = 64'h01,
  parameter int unsigned FRAME_LEN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] __in0,
  input  logic         __in_valid,
  output logic         __in_ready,
  input  logic [1:0]   __mode,
  output logic [W-1:0] __out0,
  output logic         __out_valid,
  input  logic         __out_ready,
  output logic         __frame_start
);

  localparam int unsigned KW = $clog2(PRE_LEN + 1);
  localparam logic [KW-1:0] KLast = KW'(PRE_LEN - 1);
  localparam logic [15:0] PLast = 16'(FRAME_LEN - 1);

  localparam logic [0:0] StPre    = 1'b0;
  localparam logic [0:0] StStream = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [15:0]   pcnt_q, pcnt_d;
  logic [W-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic          fs_q, fs_d;
  logic [W-1:0]  hold_q, hold_d;

  logic          load;
  logic [W-1:0]  pre_word;
  logic [W-1:0]  xform;

  assign load     = !valid_q || __out_ready;
  // Truncation to W bits gives the mod 2^W wrap.
  assign pre_word = PRE_SEED[W-1:0] + W'(k_q) * PRE_STEP[W-1:0];

  assign __in_ready    = (state_q == StStream) && load;
  assign __out0        = out_q;
  assign __out_valid   = valid_q;
  assign __frame_start = fs_q;

  always_comb begin
    xform = __in0;
    unique case (__mode)
      2'b00: xform = __in0;
      2'b01: xform = ~__in0;
      2'b10: xform = hold_q;
      2'b11: xform = '0;
      default: xform = __in0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    pcnt_d  = pcnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    hold_d  = hold_q;
    if (load) begin
      if (state_q == StPre) begin
        out_d   = pre_word;
        valid_d = 1'b1;
        fs_d    = (k_q == '0);
        if (k_q == KLast) begin
          state_d = StStream;
          k_d     = '0;
          pcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end else if (__in_valid) begin
        out_d   = xform;
        valid_d = 1'b1;
        fs_d    = 1'b0;
        if (!__mode[1]) hold_d = xform;
        if (FRAME_LEN != 0 && pcnt_q == PLast) begin
          state_d = StPre;
          k_d     = '0;
        end else if (pcnt_q != 16'hFFFF) begin
          pcnt_d = pcnt_q + 16'd1;
        end
      end else begin
        valid_d = 1'b0;
        fs_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StPre;
      k_q     <= '0;
      pcnt_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_rw_preamble_stream.sv
// Directed bench: three parameterisations share one stimulus bus; each phase resets all
// instances and checks only the instance under test.
module tb_rw_preamble_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in0;
  logic       in_valid;
  logic [1:0] mode;
  logic       out_ready;

  logic [7:0] a_out, b_out, c_out;
  logic       a_valid, b_valid, c_valid;
  logic       a_fs, b_fs, c_fs;
  logic       a_ir, b_ir, c_ir;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rw_preamble_stream #(.W(8), .PRE_LEN(4), .PRE_SEED(64'hA5), .PRE_STEP(64'h01),
                       .FRAME_LEN(0)) u_a (
    .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid), .__in_ready(a_ir),
    .__mode(mode), .__out0(a_out), .__out_valid(a_valid), .__out_ready(out_ready),
    .__frame_start(a_fs));

  rw_preamble_stream #(.W(8), .PRE_LEN(4), .PRE_SEED(64'hA5), .PRE_STEP(64'h01),
                       .FRAME_LEN(2)) u_b (
    .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid), .__in_ready(b_ir),
    .__mode(mode), .__out0(b_out), .__out_valid(b_valid), .__out_ready(out_ready),
    .__frame_start(b_fs));

  rw_preamble_stream #(.W(8), .PRE_LEN(4), .PRE_SEED(64'hFF), .PRE_STEP(64'h80),
                       .FRAME_LEN(0)) u_c (
    .clk(clk), .rst(rst), .__in0(in0), .__in_valid(in_valid), .__in_ready(c_ir),
    .__mode(mode), .__out0(c_out), .__out_valid(c_valid), .__out_ready(out_ready),
    .__frame_start(c_fs));

  typedef struct {
    string      name;
    logic       rst_n;
    logic       iv;
    logic [7:0] din;
    logic [1:0] md;
    logic       ordy;
    logic       chk_ir;
    logic       exp_ir;
    logic       exp_v;
    logic [7:0] exp_o;
    logic       exp_fs;
  } vec_t;

  function automatic vec_t mk(string n, logic r, logic iv, logic [7:0] d, logic [1:0] m,
                              logic ordy, logic ci, logic eir, logic ev, logic [7:0] eo,
                              logic efs);
    vec_t t;
    t.name = n; t.rst_n = r; t.iv = iv; t.din = d; t.md = m; t.ordy = ordy;
    t.chk_ir = ci; t.exp_ir = eir; t.exp_v = ev; t.exp_o = eo; t.exp_fs = efs;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, check in_ready before the edge, then outputs #1 after it.
  task automatic apply(input vec_t t, input int inst);
    logic [7:0] o;
    logic       v, fs, ir;
    rst = t.rst_n; in_valid = t.iv; in0 = t.din; mode = t.md; out_ready = t.ordy;
    #1;
    ir = (inst == 0) ? a_ir : (inst == 1) ? b_ir : c_ir;
    if (t.chk_ir) check({t.name, ".in_ready"}, 32'(ir), 32'(t.exp_ir));
    @(posedge clk);
    #1;
    o  = (inst == 0) ? a_out : (inst == 1) ? b_out : c_out;
    v  = (inst == 0) ? a_valid : (inst == 1) ? b_valid : c_valid;
    fs = (inst == 0) ? a_fs : (inst == 1) ? b_fs : c_fs;
    check({t.name, ".valid"}, 32'(v), 32'(t.exp_v));
    if (t.exp_v || !t.rst_n) check({t.name, ".out"}, 32'(o), 32'(t.exp_o));
    check({t.name, ".frame_start"}, 32'(fs), 32'(t.exp_fs));
  endtask

  vec_t tab[$];

  initial begin
    rst = 1'b0; in_valid = 1'b0; in0 = '0; mode = '0; out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Instance A: preamble, pass, transforms, backpressure.
    tab.push_back(mk("rst0",  0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 0));
    tab.push_back(mk("rst1",  0, 0, 8'h00, 2'b00, 1, 1, 0, 0, 8'h00, 0));
    tab.push_back(mk("pre0",  1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA5, 1));
    tab.push_back(mk("pre1",  1, 1, 8'h99, 2'b00, 1, 1, 0, 1, 8'hA6, 0));
    tab.push_back(mk("pre2",  1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA7, 0));
    tab.push_back(mk("pre3",  1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA8, 0));
    tab.push_back(mk("pass10", 1, 1, 8'h10, 2'b00, 1, 1, 1, 1, 8'h10, 0));
    tab.push_back(mk("pass11", 1, 1, 8'h11, 2'b00, 1, 1, 1, 1, 8'h11, 0));
    tab.push_back(mk("pass12", 1, 1, 8'h12, 2'b00, 1, 1, 1, 1, 8'h12, 0));
    tab.push_back(mk("inv3c", 1, 1, 8'h3C, 2'b01, 1, 1, 1, 1, 8'hC3, 0));
    tab.push_back(mk("hold55", 1, 1, 8'h55, 2'b10, 1, 1, 1, 1, 8'hC3, 0));
    tab.push_back(mk("zeroff", 1, 1, 8'hFF, 2'b11, 1, 1, 1, 1, 8'h00, 0));
    tab.push_back(mk("pass77", 1, 1, 8'h77, 2'b00, 1, 1, 1, 1, 8'h77, 0));
    tab.push_back(mk("stall0", 1, 1, 8'h88, 2'b00, 0, 1, 0, 1, 8'h77, 0));
    tab.push_back(mk("stall1", 1, 1, 8'h88, 2'b01, 0, 1, 0, 1, 8'h77, 0));
    tab.push_back(mk("stall2", 1, 1, 8'h88, 2'b00, 0, 1, 0, 1, 8'h77, 0));
    tab.push_back(mk("drain88", 1, 1, 8'h88, 2'b00, 1, 1, 1, 1, 8'h88, 0));
    tab.push_back(mk("idle",  1, 0, 8'h00, 2'b00, 1, 1, 1, 0, 8'h88, 0));
    tab.push_back(mk("idle2", 1, 0, 8'h00, 2'b00, 1, 1, 1, 0, 8'h88, 0));
    for (int i = 0; i < tab.size(); i++) apply(tab[i], 0);

    // Instance B: FRAME_LEN=2 re-inserts the preamble after two payload words.
    apply(mk("b.rst0", 0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 0), 1);
    apply(mk("b.rst1", 0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 0), 1);
    apply(mk("b.pre0", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA5, 1), 1);
    apply(mk("b.pre1", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA6, 0), 1);
    apply(mk("b.pre2", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA7, 0), 1);
    apply(mk("b.pre3", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hA8, 0), 1);
    apply(mk("b.p01",  1, 1, 8'h01, 2'b00, 1, 1, 1, 1, 8'h01, 0), 1);
    apply(mk("b.p02",  1, 1, 8'h02, 2'b00, 1, 1, 1, 1, 8'h02, 0), 1);
    apply(mk("b.re0",  1, 1, 8'h03, 2'b00, 1, 1, 0, 1, 8'hA5, 1), 1);
    apply(mk("b.re1",  1, 1, 8'h03, 2'b00, 1, 1, 0, 1, 8'hA6, 0), 1);
    apply(mk("b.re2",  1, 1, 8'h03, 2'b00, 1, 1, 0, 1, 8'hA7, 0), 1);
    apply(mk("b.re3",  1, 1, 8'h03, 2'b00, 1, 1, 0, 1, 8'hA8, 0), 1);
    apply(mk("b.p03",  1, 1, 8'h03, 2'b00, 1, 1, 1, 1, 8'h03, 0), 1);

    // Instance C: wrapping preamble arithmetic, mid-preamble reset, hold reg cleared.
    apply(mk("c.rst0", 0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 0), 2);
    apply(mk("c.rst1", 0, 0, 8'h00, 2'b00, 1, 0, 0, 0, 8'h00, 0), 2);
    apply(mk("c.pre0", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hFF, 1), 2);
    apply(mk("c.pre1", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'h7F, 0), 2);
    apply(mk("c.pre2", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hFF, 0), 2);
    apply(mk("c.midrst", 0, 0, 8'h00, 2'b00, 1, 1, 0, 0, 8'h00, 0), 2);
    apply(mk("c.again0", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hFF, 1), 2);
    apply(mk("c.again1", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'h7F, 0), 2);
    apply(mk("c.again2", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'hFF, 0), 2);
    apply(mk("c.again3", 1, 0, 8'h00, 2'b00, 1, 1, 0, 1, 8'h7F, 0), 2);
    apply(mk("c.hold0", 1, 1, 8'h12, 2'b10, 1, 1, 1, 1, 8'h00, 0), 2);
    apply(mk("c.inv",   1, 1, 8'h0F, 2'b01, 1, 1, 1, 1, 8'hF0, 0), 2);
    apply(mk("c.hold1", 1, 1, 8'h12, 2'b10, 1, 1, 1, 1, 8'hF0, 0), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
